// File: rtl/tile_pixel_walker.sv
// tile_pixel_walker: walks every pixel of a square tile in raster order.
// Edge functions and depth are stepped incrementally. One fragment is
// emitted for each pixel that lies inside the triangle.
// Coordinate ports are packed as {z, y, x}, with x in the low FX_TOTAL_BITS.
module tile_pixel_walker #(
  parameter int FX_TOTAL_BITS   = 16,
  parameter int FX_FRAC_BITS    = 4,
  parameter int TILE_WIDTH_BITS = 3,
  parameter int META_BITS       = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_vld,
  output logic                                     in_rdy,
  input  logic [3*FX_TOTAL_BITS-1:0]               in_abs_pos,
  input  logic [3*FX_TOTAL_BITS-1:0]               in_delta_0,
  input  logic [3*FX_TOTAL_BITS-1:0]               in_delta_1,
  input  logic [3*FX_TOTAL_BITS-1:0]               in_delta_2,
  input  logic signed [2*FX_TOTAL_BITS-1:0]        in_edge_0,
  input  logic signed [2*FX_TOTAL_BITS-1:0]        in_edge_1,
  input  logic signed [2*FX_TOTAL_BITS-1:0]        in_edge_2,
  input  logic signed [FX_TOTAL_BITS-1:0]          in_dzdx,
  input  logic signed [FX_TOTAL_BITS-1:0]          in_dzdy,
  input  logic signed [2*FX_TOTAL_BITS-1:0]        in_z_current,
  input  logic [META_BITS-1:0]                     in_metadata,
  output logic                                     out_vld,
  input  logic                                     out_rdy,
  output logic [FX_TOTAL_BITS-FX_FRAC_BITS-1:0]    out_x,
  output logic [FX_TOTAL_BITS-FX_FRAC_BITS-1:0]    out_y,
  output logic signed [FX_TOTAL_BITS-1:0]          out_z,
  output logic [META_BITS-1:0]                     out_metadata,
  output logic                                     tile_done
);

  localparam int W  = FX_TOTAL_BITS;
  localparam int F  = FX_FRAC_BITS;
  localparam int AW = 2 * FX_TOTAL_BITS;
  localparam int IW = FX_TOTAL_BITS - FX_FRAC_BITS;
  localparam int T  = TILE_WIDTH_BITS;
  localparam logic [T-1:0] LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_DRAIN} state_t;

  // Sign-extend a 12.4 delta to accumulator width, then align it to 24.8.
  function automatic logic [AW-1:0] fx_step(input logic [W-1:0] d);
    logic [AW-1:0] ext;
    ext = {{(AW-W){d[W-1]}}, d};
    return ext << F;
  endfunction

  state_t               r_state;
  logic                 r_in_rdy;
  logic                 r_tile_done;
  logic [T-1:0]         r_col;
  logic [T-1:0]         r_row;
  logic [2:0][AW-1:0]   r_edge;
  logic [2:0][AW-1:0]   r_row_edge;
  logic [2:0][W-1:0]    r_dx;
  logic [2:0][W-1:0]    r_dy;
  logic [AW-1:0]        r_z_acc;
  logic [AW-1:0]        r_row_z;
  logic [W-1:0]         r_dzdx;
  logic [W-1:0]         r_dzdy;
  logic [IW-1:0]        r_base_x;
  logic [IW-1:0]        r_base_y;
  logic [META_BITS-1:0] r_meta;

  logic                 r_out_vld;
  logic [IW-1:0]        r_out_x;
  logic [IW-1:0]        r_out_y;
  logic [W-1:0]         r_out_z;
  logic [META_BITS-1:0] r_out_meta;

  logic                 w_inside;
  logic                 w_out_free;
  logic                 w_emit;
  logic                 w_advance;
  logic [2:0][AW-1:0]   w_row_edge_nxt;
  logic [AW-1:0]        w_row_z_nxt;
  logic                 w_unused_bits;

  // These input bits are not consumed by this stage: the z components and
  // the fractional part of the tile origin.
  assign w_unused_bits = ^{in_abs_pos[3*W-1:2*W], in_abs_pos[W+F-1:W], in_abs_pos[F-1:0],
                           in_delta_0[3*W-1:2*W], in_delta_1[3*W-1:2*W], in_delta_2[3*W-1:2*W]};

  // Pixel coverage and handshake decisions for the pixel under evaluation.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_inside   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (r_edge[i][AW-1]) w_inside = 1'b0;
    end
    w_out_free = !r_out_vld || out_rdy;
    w_emit     = (r_state == S_WALK) && w_inside && w_out_free;
    w_advance  = (r_state == S_WALK) && (!w_inside || w_out_free);
  end

  // Row-start values for the next row: step down one pixel in y.
  always_comb begin
    w_row_edge_nxt = '0;
    for (int i = 0; i < 3; i++) begin
      w_row_edge_nxt[i] = r_row_edge[i] - fx_step(r_dx[i]);
    end
    w_row_z_nxt = r_row_z + fx_step(r_dzdy);
  end

  // Walker FSM, accumulators and fragment output register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: these are plain registers, not a memory, so all of them are
      // cleared; a reset mid-walk leaves no stale job state behind.
      r_state     <= S_IDLE;
      r_in_rdy    <= 1'b1;
      r_tile_done <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
      r_edge      <= '0;
      r_row_edge  <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_z_acc     <= '0;
      r_row_z     <= '0;
      r_dzdx      <= '0;
      r_dzdy      <= '0;
      r_base_x    <= '0;
      r_base_y    <= '0;
      r_meta      <= '0;
      r_out_vld   <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_z     <= '0;
      r_out_meta  <= '0;
    end else begin
      r_tile_done <= 1'b0;

      if (w_emit) begin
        r_out_vld  <= 1'b1;
        r_out_x    <= r_base_x + IW'(r_col);
        r_out_y    <= r_base_y + IW'(r_row);
        r_out_z    <= r_z_acc[W+F-1:F];
        r_out_meta <= r_meta;
      end else if (out_rdy) begin
        r_out_vld  <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (in_vld && r_in_rdy) begin
            r_in_rdy   <= 1'b0;
            r_state    <= S_WALK;
            r_col      <= '0;
            r_row      <= '0;
            r_base_x   <= in_abs_pos[W-1:F];
            r_base_y   <= in_abs_pos[2*W-1:W+F];
            r_dx[0]    <= in_delta_0[W-1:0];
            r_dy[0]    <= in_delta_0[2*W-1:W];
            r_dx[1]    <= in_delta_1[W-1:0];
            r_dy[1]    <= in_delta_1[2*W-1:W];
            r_dx[2]    <= in_delta_2[W-1:0];
            r_dy[2]    <= in_delta_2[2*W-1:W];
            r_edge     <= {in_edge_2, in_edge_1, in_edge_0};
            r_row_edge <= {in_edge_2, in_edge_1, in_edge_0};
            r_z_acc    <= in_z_current;
            r_row_z    <= in_z_current;
            r_dzdx     <= in_dzdx;
            r_dzdy     <= in_dzdy;
            r_meta     <= in_metadata;
          end
        end

        S_WALK: begin
          if (w_advance) begin
            if (r_col != LAST) begin
              for (int i = 0; i < 3; i++) begin
                r_edge[i] <= r_edge[i] + fx_step(r_dy[i]);
              end
              r_z_acc <= r_z_acc + fx_step(r_dzdx);
              r_col   <= r_col + 1'b1;
            end else begin
              r_row_edge <= w_row_edge_nxt;
              r_edge     <= w_row_edge_nxt;
              r_row_z    <= w_row_z_nxt;
              r_z_acc    <= w_row_z_nxt;
              r_col      <= '0;
              r_row      <= r_row + 1'b1;
              if (r_row == LAST) r_state <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          // The done pulse is held in DRAIN for one cycle; ready returns after.
          if (r_tile_done) begin
            r_state  <= S_IDLE;
            r_in_rdy <= 1'b1;
          end else if (!r_out_vld || out_rdy) begin
            r_tile_done <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_rdy       = r_in_rdy;
  assign tile_done    = r_tile_done;
  assign out_vld      = r_out_vld;
  assign out_x        = r_out_x;
  assign out_y        = r_out_y;
  assign out_z        = r_out_z;
  assign out_metadata = r_out_meta;

endmodule

// File: tb/tb_tile_pixel_walker.sv
// tb_tile_pixel_walker: directed jobs against a closed-form fragment model.
// The model computes each pixel's edges and depth as origin + c*dx + r*dy
// and queues the expected fragments. A monitor compares every accepted
// fragment and checks that a stalled output holds steady.
module tb_tile_pixel_walker;

  localparam int W    = 16;
  localparam int F    = 4;
  localparam int T    = 3;
  localparam int M    = 8;
  localparam int SIDE = 1 << T;
  localparam int N    = SIDE * SIDE;

  typedef struct packed {
    logic [15:0]       ax;
    logic [15:0]       ay;
    logic [2:0][15:0]  dx;
    logic [2:0][15:0]  dy;
    logic [2:0][31:0]  edge_v;
    logic [15:0]       dzdx;
    logic [15:0]       dzdy;
    logic [31:0]       z0;
    logic [7:0]        meta;
  } job_t;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [15:0] z;
    logic [7:0]  meta;
  } frag_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_vld;
  logic               in_rdy;
  logic [3*W-1:0]     in_abs_pos, in_delta_0, in_delta_1, in_delta_2;
  logic signed [2*W-1:0] in_edge_0, in_edge_1, in_edge_2, in_z_current;
  logic signed [W-1:0]   in_dzdx, in_dzdy;
  logic [M-1:0]       in_metadata;
  logic               out_vld;
  logic               out_rdy;
  logic [W-F-1:0]     out_x, out_y;
  logic signed [W-1:0] out_z;
  logic [M-1:0]       out_metadata;
  logic               tile_done;

  always #5 clk = ~clk;

  tile_pixel_walker #(
    .FX_TOTAL_BITS(W), .FX_FRAC_BITS(F), .TILE_WIDTH_BITS(T), .META_BITS(M)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .in_abs_pos(in_abs_pos),
    .in_delta_0(in_delta_0), .in_delta_1(in_delta_1), .in_delta_2(in_delta_2),
    .in_edge_0(in_edge_0), .in_edge_1(in_edge_1), .in_edge_2(in_edge_2),
    .in_dzdx(in_dzdx), .in_dzdy(in_dzdy), .in_z_current(in_z_current),
    .in_metadata(in_metadata),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_metadata(out_metadata),
    .tile_done(tile_done)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc = 0;
  int    frag_count = 0;
  int    done_count = 0;
  frag_t exp_q[$];
  frag_t cur;
  frag_t held;
  bit    hold_prev = 1'b0;

  assign cur = {out_x, out_y, out_z, out_metadata};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected fragments of one job, in raster order.
  task automatic push_expected(input job_t j);
    for (int r = 0; r < SIDE; r++) begin
      for (int c = 0; c < SIDE; c++) begin
        bit in_tri;
        int e;
        int z;
        logic [31:0] zb;
        frag_t f;
        in_tri = 1'b1;
        for (int i = 0; i < 3; i++) begin
          e = int'($signed(j.edge_v[i])) + c * (int'($signed(j.dy[i])) * 16)
              - r * (int'($signed(j.dx[i])) * 16);
          if (e < 0) in_tri = 1'b0;
        end
        if (in_tri) begin
          z = int'($signed(j.z0)) + c * (int'($signed(j.dzdx)) * 16)
              + r * (int'($signed(j.dzdy)) * 16);
          zb     = z;
          f.x    = j.ax[15:4] + 12'(c);
          f.y    = j.ay[15:4] + 12'(r);
          f.z    = zb[19:4];
          f.meta = j.meta;
          exp_q.push_back(f);
        end
      end
    end
  endtask

  function automatic job_t full_job(input logic [7:0] meta);
    job_t j;
    j = '0;
    j.ax = 16'h0180;
    j.ay = 16'h0080;
    for (int i = 0; i < 3; i++) j.edge_v[i] = 32'h1000_0000;
    j.z0   = 32'h0000_1000;
    j.dzdx = 16'h0010;
    j.dzdy = 16'h0020;
    j.meta = meta;
    return j;
  endfunction

  function automatic job_t diag_job(input logic [7:0] meta);
    job_t j;
    j = full_job(meta);
    j.edge_v[0] = 32'h0;
    j.dx[0]     = 16'h0010;
    j.dy[0]     = 16'h0010;
    return j;
  endfunction

  task automatic set_inputs(input job_t j);
    in_abs_pos   = {16'hDEAD, j.ay, j.ax};
    in_delta_0   = {16'hBEEF, j.dy[0], j.dx[0]};
    in_delta_1   = {16'hBEEF, j.dy[1], j.dx[1]};
    in_delta_2   = {16'hBEEF, j.dy[2], j.dx[2]};
    in_edge_0    = j.edge_v[0];
    in_edge_1    = j.edge_v[1];
    in_edge_2    = j.edge_v[2];
    in_dzdx      = j.dzdx;
    in_dzdy      = j.dzdy;
    in_z_current = j.z0;
    in_metadata  = j.meta;
  endtask

  // Present a job and wait for it to be accepted; returns the accept edge.
  task automatic start_job(input job_t j, output int acc_cyc);
    int k;
    set_inputs(j);
    in_vld = 1'b1;
    k = 0;
    while (!in_rdy && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("accept_wait", 64'(k < 200), 64'd1);
    push_expected(j);
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_vld = 1'b0;
    set_inputs('0);
  endtask

  task automatic wait_done(input string name, input int acc_cyc, input int exp_lat);
    int k;
    k = 0;
    while (!tile_done && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_done_seen"}, 64'(tile_done), 64'd1);
    if (tile_done) begin
      check({name, "_done_latency"}, 64'(cyc - acc_cyc), 64'(exp_lat));
      check({name, "_rdy_low_at_done"}, 64'(in_rdy), 64'd0);
      @(posedge clk); #1;
      check({name, "_rdy_after_done"}, 64'(in_rdy), 64'd1);
      check({name, "_done_one_cycle"}, 64'(tile_done), 64'd0);
    end
  endtask

  // Fragment monitor: compares each accepted fragment and checks that a
  // stalled output does not change.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev <= 1'b0;
    end else begin
      if (out_vld && hold_prev) check("hold_stable", 64'(cur), 64'(held));
      if (out_vld && out_rdy) begin
        check("frag_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("frag", 64'(cur), 64'(exp_q.pop_front()));
        frag_count <= frag_count + 1;
      end
      if (tile_done) done_count <= done_count + 1;
      held      <= cur;
      hold_prev <= out_vld && !out_rdy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc_b, done_a, fc, dc, k, bad;
    job_t ja, jb;

    in_vld  = 1'b0;
    out_rdy = 1'b1;
    set_inputs('0);

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_rdy", 64'(in_rdy), 64'd1);
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_tile_done", 64'(tile_done), 64'd0);
    check("rst_out_xyz", 64'({out_x, out_y, out_z, out_metadata}), 64'd0);
    rst_n = 1'b1;

    // Pin the model with hand-computed values.
    push_expected(full_job(8'h11));
    check("model_full_count", 64'(exp_q.size()), 64'd64);
    check("model_z_0_0", 64'(exp_q[0].z), 64'h100);
    check("model_z_7_0", 64'(exp_q[7].z), 64'h170);
    check("model_z_7_7", 64'(exp_q[63].z), 64'h250);
    check("model_xy_first", 64'({exp_q[0].x, exp_q[0].y}), 64'({12'd24, 12'd8}));
    check("model_xy_last", 64'({exp_q[63].x, exp_q[63].y}), 64'({12'd31, 12'd15}));
    exp_q.delete();
    push_expected(diag_job(8'h22));
    check("model_diag_count", 64'(exp_q.size()), 64'd36);
    bad = 0;
    foreach (exp_q[i]) if (int'(exp_q[i].x) - 24 < int'(exp_q[i].y) - 8) bad++;
    check("model_diag_col_ge_row", 64'(bad), 64'd0);
    check("model_diag_last", 64'({exp_q[35].x, exp_q[35].y}), 64'({12'd31, 12'd15}));
    exp_q.delete();

    // Full coverage.
    fc = frag_count; dc = done_count;
    start_job(full_job(8'h11), acc);
    wait_done("full", acc, N + 1);
    check("full_frags", 64'(frag_count - fc), 64'd64);
    check("full_done_count", 64'(done_count - dc), 64'd1);
    check("full_queue_empty", 64'(exp_q.size()), 64'd0);

    // Empty tile.
    ja = full_job(8'h33);
    ja.edge_v[0] = 32'hFFFF_FFFF;
    fc = frag_count;
    start_job(ja, acc);
    wait_done("empty", acc, 65);
    check("empty_frags", 64'(frag_count - fc), 64'd0);

    // Diagonal.
    fc = frag_count;
    start_job(diag_job(8'h22), acc);
    wait_done("diag", acc, N + 1);
    check("diag_frags", 64'(frag_count - fc), 64'd36);
    check("diag_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: stall with fragment 5 waiting.
    fc = frag_count;
    start_job(full_job(8'h44), acc);
    k = 0;
    while (frag_count < fc + 5 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp_reached_frag5", 64'(frag_count - fc), 64'd5);
    out_rdy = 1'b0;
    check("bp_frag5_start", 64'({out_vld, out_x, out_y, out_z}), 64'({1'b1, 12'd29, 12'd8, 16'h0150}));
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("bp_frag5_end", 64'({out_vld, out_x, out_y, out_z}), 64'({1'b1, 12'd29, 12'd8, 16'h0150}));
    out_rdy = 1'b1;
    wait_done("bp", acc, N + 1 + 10);
    check("bp_frags", 64'(frag_count - fc), 64'd64);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Handshake gating: in_vld held high, inputs change mid-walk.
    ja = full_job(8'h55);
    jb = diag_job(8'h5A);
    jb.ax = 16'h0400;
    jb.ay = 16'h0200;
    jb.z0 = 32'h0000_3000;
    jb.dzdx = 16'hFFF0;
    fc = frag_count;
    set_inputs(ja);
    in_vld = 1'b1;
    k = 0;
    while (!in_rdy && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    push_expected(ja);
    @(posedge clk); #1;
    acc = cyc;
    set_inputs(jb);
    push_expected(jb);
    done_a = -1;
    k = 0;
    while (!in_rdy && k < 300) begin
      @(posedge clk); #1;
      if (tile_done) done_a = cyc;
      k++;
    end
    check("gate_done_before_rdy", 64'(done_a >= 0), 64'd1);
    check("gate_rdy_after_done", 64'(cyc - done_a), 64'd1);
    @(posedge clk); #1;
    acc_b = cyc;
    in_vld = 1'b0;
    set_inputs(full_job(8'hEE));
    check("gate_accepted_b", 64'(in_rdy), 64'd0);
    check("gate_job_spacing", 64'(acc_b - acc), 64'(N + 3));
    wait_done("gate_b", acc_b, N + 1);
    check("gate_frags", 64'(frag_count - fc), 64'd100);
    check("gate_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-walk.
    fc = frag_count;
    start_job(full_job(8'h66), acc);
    k = 0;
    while (frag_count < fc + 20 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rstmid_out_vld", 64'(out_vld), 64'd0);
    check("rstmid_outputs", 64'({out_x, out_y, out_z, out_metadata}), 64'd0);
    check("rstmid_in_rdy", 64'(in_rdy), 64'd1);
    check("rstmid_tile_done", 64'(tile_done), 64'd0);
    fc = frag_count; dc = done_count;
    repeat (80) @(posedge clk);
    #1;
    check("rstmid_no_done", 64'(done_count - dc), 64'd0);
    check("rstmid_no_frags", 64'(frag_count - fc), 64'd0);
    start_job(diag_job(8'h77), acc);
    wait_done("after_rst", acc, N + 1);
    check("after_rst_frags", 64'(frag_count - fc), 64'd36);
    check("after_rst_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_pixel_walker.md
# tile_pixel_walker

Rasterization stage directly downstream of the per-tile triangle setup stage. It accepts one tile job per handshake: tile origin, edge-function values at the origin, edge deltas, z plane slopes and origin z. It walks every pixel of the square tile in raster order, stepping the edge functions and z incrementally. For each pixel inside the triangle it emits one fragment (pixel x/y, depth, metadata) to the depth/fragment stage.

## Interface
- `FX_TOTAL_BITS`, default 16: fixed-point word width, 12.4 format.
- `FX_FRAC_BITS`, default 4: fractional bits.
- `TILE_WIDTH_BITS`, default 3: tile is 2^TILE_WIDTH_BITS pixels square (8x8).
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset. Synchronous, active-low.
- `in_vld`, in, 1: tile job valid.
- `in_rdy`, out, 1: walker idle and able to accept a job.
- `in_abs_pos`, in, coord_3d_t: tile origin pixel, 12.4. Only .x and .y are used.
- `in_delta_0`, `in_delta_1`, `in_delta_2`, in, coord_3d_t: edge deltas, 12.4. Only .x and .y are used.
- `in_edge_0`, `in_edge_1`, `in_edge_2`, in, 2*FX_TOTAL_BITS signed: edge functions at the origin, 24.8.
- `in_dzdx`, `in_dzdy`, in, FX_TOTAL_BITS signed: z slopes, 12.4.
- `in_z_current`, in, 2*FX_TOTAL_BITS signed: z at the origin, 24.8.
- `in_metadata`, in, metadata_t: passed through to fragments.
- `out_vld`, out, 1: fragment valid.
- `out_rdy`, in, 1: downstream accepts the fragment.
- `out_x`, `out_y`, out, FX_TOTAL_BITS-FX_FRAC_BITS: integer pixel coordinates.
- `out_z`, out, FX_TOTAL_BITS signed: depth, 12.4.
- `out_metadata`, out, metadata_t: metadata of the job.
- `tile_done`, out, 1: one-cycle pulse when a job has fully completed.

## Operation
- States: IDLE, WALK, DRAIN.
- **IDLE**
  - `in_rdy`=1.
  - On `in_vld && in_rdy`, latch all inputs and set col=row=0.
  - Load the current edge/z registers and the row-start edge/z registers from the inputs.
  - Go to WALK.
- **WALK**, one pixel evaluated per cycle.
  - The pixel is inside iff all three current edges are >= 0 (signed).
- **Emit rule**
  - Inside and (`!out_vld` or `out_rdy`): load the output register and advance.
  - Inside and output register full and not accepted: stall. Nothing advances.
  - Outside: advance without emitting. A waiting output is unaffected.
- **Output register** contents for a loaded pixel:
  - `out_x` = in_abs_pos.x[FX_TOTAL_BITS-1:FX_FRAC_BITS] + col.
  - `out_y` = integer part of in_abs_pos.y + row.
  - `out_z` = z_acc[FX_TOTAL_BITS+FX_FRAC_BITS-1:FX_FRAC_BITS].
- **Advance within a row** (col < last):
  - edge_i += sext(delta_i.y) << FX_FRAC_BITS.
  - z_acc += sext(dzdx) << FX_FRAC_BITS.
  - col++.
- **Advance at row end** (col = last):
  - row_edge_i -= sext(delta_i.x) << FX_FRAC_BITS; current edges take the new row values.
  - row_z += sext(dzdy) << FX_FRAC_BITS; z_acc takes the new row value.
  - col=0, row++.
- **Advance on the final pixel** (col=row=last): go to DRAIN.
- All stepping is 2*FX_TOTAL_BITS-wide, two's-complement wrap, no saturation.
- **DRAIN**
  - Wait until `!out_vld`, or `out_vld && out_rdy` this cycle.
  - Then pulse `tile_done` for one cycle and return to IDLE with `in_rdy`=1.
- **Output handshake**
  - `out_vld` clears on `out_rdy` unless a new fragment loads in the same cycle.
  - `out_*` is stable while `out_vld && !out_rdy`.
- A job producing zero fragments still walks all pixels and pulses `tile_done`.
- `in_vld` is ignored outside IDLE. Inputs are sampled only at the accept edge.

## Timing
- Reset values:
  - All outputs 0, including `out_vld`=0 and `tile_done`=0.
  - `in_rdy`=1, state IDLE.
  - Internal accumulators 0.
- Reset asserted mid-walk aborts the job: no further fragments and no `tile_done`.
- Accept at edge T: pixel (0,0) is evaluated in cycle T+1.
  - Its fragment, if inside, has `out_vld`=1 from T+2.
- With `out_rdy` held at 1, a tile of N=2^(2·TILE_WIDTH_BITS) pixels takes N WALK cycles.
- With no backpressure, `tile_done` asserts N+1 cycles after entering WALK. `in_rdy` returns the cycle after.
- Peak throughput: 1 fragment/cycle. Minimum job spacing: N+3 cycles.

## Test plan
- **Full coverage.** edges=0x1000_0000, all deltas 0, abs_pos=(0x180,0x080), z_current=0x1000, dzdx=0x0010, dzdy=0x0020, out_rdy=1.
  - 64 fragments in raster order, x=24..31, y=8..15.
  - (0,0) z=0x100, (7,0) z=0x170, (7,7) z=0x250.
  - `tile_done` once.
- **Empty tile.** edge_0=-1, all deltas 0.
  - No `out_vld`.
  - `tile_done` 65 cycles after accept; `in_rdy` high again the next cycle.
- **Diagonal.** edge_0=0, delta_0=(x=0x10,y=0x10); edges 1/2 = 0x1000_0000 with deltas 0.
  - Exactly 36 fragments, all with col >= row.
  - First (0,0), last (7,7).
- **Backpressure.** Full-coverage job with out_rdy=0 for 10 cycles starting at fragment 5.
  - `out_x`/`out_y`/`out_z` hold fragment 5 unchanged.
  - All 64 fragments delivered, no duplicates.
- **Handshake gating.** Hold in_vld=1 throughout a job with new values.
  - Second job accepted only after `tile_done`.
  - Its values are unaffected by the mid-walk input changes.
- **Reset mid-walk.** Assert rst_n=0 at pixel 20 for 1 cycle.
  - Outputs 0, `in_rdy`=1, no `tile_done`.
  - A following job runs correctly.
